// File: rtl/ddr_wr_burst_engine.sv
// rtl/ddr_wr_burst_engine.sv - splits a beat-count write request into 4 KB-safe AXI4 INCR bursts
// fed from a first-word-fall-through FIFO.
module ddr_wr_burst_engine #(
  parameter int ADDR_WIDTH = 30,
  parameter int NUM_WIDTH  = 16,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_BURST  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    addr_valid,
  input  logic [ADDR_WIDTH-1:0]   ddr_addr,
  input  logic [NUM_WIDTH-1:0]    ddr_num,
  output logic                    ddr_done,
  output logic                    busy,
  output logic                    err,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  input  logic [NUM_WIDTH-1:0]    fifo_count,
  output logic                    fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  typedef enum logic [2:0] {IDLE, CALC, ADDR, WAIT_DATA, DATA, RESP, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [NUM_WIDTH-1:0]  remain;
  logic [NUM_WIDTH-1:0]  blen;
  logic [NUM_WIDTH-1:0]  beat_cnt;
  logic [NUM_WIDTH-1:0]  room;
  logic [NUM_WIDTH-1:0]  blen_calc;

  // cur_addr is always 32-byte aligned here, so beats left in the 4 KB page = 128 - addr[11:5].
  always_comb begin
    room      = NUM_WIDTH'(9'd128 - {2'b00, cur_addr[11:5]});
    blen_calc = remain;
    if (NUM_WIDTH'(MAX_BURST) < blen_calc) blen_calc = NUM_WIDTH'(MAX_BURST);
    if (room < blen_calc) blen_calc = room;
  end

  assign awsize     = 3'b101;
  assign awburst    = 2'b01;
  assign wstrb      = '1;
  // wdata is a straight wire from the FWFT head so each pop exposes the next beat immediately.
  assign wdata      = fifo_dout;
  assign fifo_rd_en = wvalid & wready & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      remain   <= '0;
      blen     <= '0;
      beat_cnt <= '0;
      awaddr   <= '0;
      awlen    <= '0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      wlast    <= 1'b0;
      bready   <= 1'b0;
      ddr_done <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ddr_done <= 1'b0;
          if (addr_valid) begin
            cur_addr <= ddr_addr;
            remain   <= ddr_num;
            busy     <= 1'b1;
            if (ddr_addr[4:0] != 5'd0) begin
              err      <= 1'b1;
              ddr_done <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (remain == '0) begin
            ddr_done <= 1'b1;
            state    <= DONE;
          end else begin
            blen    <= blen_calc;
            awaddr  <= cur_addr;
            awlen   <= 8'(blen_calc - NUM_WIDTH'(1));
            awvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            state   <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // Whole burst must be buffered so wvalid never gaps mid-burst.
          if (fifo_count >= blen) begin
            wvalid   <= 1'b1;
            wlast    <= (blen == NUM_WIDTH'(1));
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (wready) begin
            if (wlast) begin
              wvalid   <= 1'b0;
              wlast    <= 1'b0;
              bready   <= 1'b1;
              beat_cnt <= '0;
              state    <= RESP;
            end else begin
              beat_cnt <= beat_cnt + NUM_WIDTH'(1);
              wlast    <= (beat_cnt + NUM_WIDTH'(2) == blen);
            end
          end
        end
        RESP: begin
          if (bvalid) begin
            bready   <= 1'b0;
            if (bresp != 2'b00) err <= 1'b1;
            cur_addr <= cur_addr + (ADDR_WIDTH'(blen) << 5);
            remain   <= remain - blen;
            state    <= CALC;
          end
        end
        DONE: begin
          ddr_done <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ddr_wr_burst_engine.md
DDR_WR_BURST_ENGINE -- requirements
Module: ddr_wr_burst_engine

Interface
REQ-001 Parameter ADDR_WIDTH, default 30, is the byte-address width of the DDR port.
REQ-002 Parameter NUM_WIDTH, default 16, is the width of the per-request beat count.
REQ-003 Parameter DATA_WIDTH, default 256, is the beat width; one beat is 32 bytes.
REQ-004 Parameter MAX_BURST, default 16, is the maximum beats per AXI burst.
REQ-005 clk  in  1  clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 addr_valid  in  1  request from the address controller; sampled only in IDLE.
REQ-008 ddr_addr  in  ADDR_WIDTH  start byte address of the request; must be 32-byte aligned.
REQ-009 ddr_num  in  NUM_WIDTH  request length in beats.
REQ-010 ddr_done  out  1  single-cycle pulse when the request completes.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 err  out  1  sticky error flag; cleared only by rst.
REQ-013 fifo_dout  in  DATA_WIDTH  first-word-fall-through pixel FIFO head.
REQ-014 fifo_count  in  NUM_WIDTH  beats currently stored in the FIFO.
REQ-015 fifo_rd_en  out  1  FIFO pop.
REQ-016 awaddr/awlen[7:0]/awvalid  out; awready  in  AXI4 write-address channel; awsize fixed at 3'b101 and awburst fixed at INCR.
REQ-017 wdata/wlast/wvalid  out; wready  in  AXI4 write-data channel; wstrb tied all-ones.
REQ-018 bresp[1:0]/bvalid  in; bready  out  AXI4 write-response channel.

Function
REQ-019 The FSM SHALL use the states IDLE, CALC, ADDR, WAIT_DATA, DATA, RESP and DONE.
REQ-020 IDLE: when addr_valid=1, the block SHALL latch cur_addr=ddr_addr and remain=ddr_num, then go to CALC.
REQ-021 IDLE: when addr_valid=1 and ddr_addr[4:0]!=0, the block SHALL set err, perform no AXI traffic, and go to DONE.
REQ-022 CALC: when remain=0, the FSM SHALL go to DONE; otherwise it SHALL compute blen=min(remain, MAX_BURST, (4096-cur_addr[11:0])/32) and go to ADDR.
REQ-023 No burst SHALL cross a 4 KB boundary.
REQ-024 ADDR: the block SHALL hold awvalid=1, awaddr=cur_addr and awlen=blen-1 until awready=1; on that handshake it SHALL go to WAIT_DATA.
REQ-025 WAIT_DATA: the block SHALL wait until fifo_count>=blen, then go to DATA.
REQ-026 WAIT_DATA guarantees that wvalid, once raised, never drops before wlast.
REQ-027 DATA: the block SHALL drive wvalid=1 and wdata=fifo_dout.
REQ-028 DATA: fifo_rd_en SHALL equal wvalid&wready on the same cycle, giving zero-latency pops.
REQ-029 DATA: the beat counter SHALL increment on each wvalid&wready; wlast SHALL equal 1 exactly when count==blen-1.
REQ-030 DATA: on the last handshake the FSM SHALL go to RESP.
REQ-031 RESP: bready SHALL be 1; on bvalid=1 the FSM SHALL go to CALC and update cur_addr+=blen*32 and remain-=blen in the same cycle.
REQ-032 RESP: bresp!=2'b00 SHALL set err, and the request SHALL continue.
REQ-033 DONE: ddr_done=1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-034 addr_valid asserted outside IDLE SHALL be ignored; the controller holds it until ddr_done.
REQ-035 A request that is still asserted in the cycle after DONE SHALL be treated as a new request.
REQ-036 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no overflow flag is produced.
REQ-037 Outputs SHALL be registered, except fifo_rd_en, which is combinational by REQ-028.
REQ-038 Latency: ADDR SHALL follow addr_valid by 2 cycles (IDLE to CALC to ADDR).
REQ-039 Latency: the next burst's ADDR SHALL follow its bvalid by 2 cycles.

Reset
REQ-040 On rst, the FSM SHALL return to IDLE within one cycle, including mid-burst, and the partial transaction SHALL be abandoned.
REQ-041 On rst, awvalid, wvalid, wlast, bready, fifo_rd_en, ddr_done, busy and err SHALL be 0.
REQ-042 On rst, cur_addr, remain, blen and the beat counter SHALL be 0.
REQ-043 The DDR controller is reset together with this block, so an abandoned transaction needs no recovery.

Verification
REQ-044 Scenario 1: ddr_addr=0x0, ddr_num=40, FIFO full, AXI always ready -> bursts awaddr 0x000/0x200/0x400 with awlen 15/15/7; 40 pops; one ddr_done.
REQ-045 Scenario 2: ddr_addr=0xF80, ddr_num=16 -> bursts 0xF80 awlen 3, then 0x1000 awlen 11; no 4 KB crossing.
REQ-046 Scenario 3: fifo_count held at 10 with ddr_num=16 -> awvalid handshake occurs, wvalid stays 0; count reaches 16 -> 16 contiguous beats with wready=1.
REQ-047 Scenario 4: random wready/awready/bvalid stalls, ddr_num=100 -> data matches FIFO order; wlast on beats 16,32,...,96,100.
REQ-048 Scenario 5: second burst returns bresp=2'b10 -> err=1 and stays 1; request completes with ddr_done; ddr_num=0 -> ddr_done 2 cycles after addr_valid, no AXI traffic; ddr_addr=0x10 -> err=1 and ddr_done with no AXI traffic.
REQ-049 Scenario 6: rst asserted mid-DATA on beat 5 -> next cycle all outputs 0 and state IDLE; a new request afterwards completes normally.
